// File: rtl/pwm_capture.sv
// pwm_capture: measures the duty of a free-running PWM waveform and flags bad periods.
// Ports:
//   CLK          - sole clock, rising edge
//   RST_N        - synchronous active-low reset
//   wave_i       - asynchronous PWM input, high = on
//   step_o       - last measured duty (high cycles per period), saturated to 255
//   valid_o      - one-cycle strobe, step_o updated this cycle
//   period_err_o - one-cycle strobe, measured period outside PERIOD-TOL..PERIOD+TOL
//   locked_o     - a good measurement has been taken since the last error or reset
module pwm_capture #(
    parameter int unsigned PERIOD = 256,
    parameter int unsigned TOL    = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       wave_i,
    output logic [7:0] step_o,
    output logic       valid_o,
    output logic       period_err_o,
    output logic       locked_o
);

    localparam int unsigned CW      = 10;
    localparam int unsigned PW      = CW + 1;
    localparam int unsigned SW      = 8;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
    localparam int unsigned STEP_MAX = (1 << SW) - 1;
    localparam int unsigned P_MIN   = (PERIOD > TOL) ? PERIOD - TOL : 0;
    localparam int unsigned P_MAX   = PERIOD + TOL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic            sync_q1, wave_s, wave_d;
    logic            rise_c, fall_c;
    logic [CW-1:0]   high_cnt, high_nx;
    logic [CW-1:0]   low_cnt, low_nx;
    logic [CW-1:0]   idle_cnt;
    logic            pend_valid, pend_valid_nx;
    logic            pend_err, pend_err_nx;
    logic [SW-1:0]   pend_step, pend_step_nx;
    logic [PW-1:0]   period_c;
    logic            period_ok_c;
    logic            idle_hit_c;
    logic [SW-1:0]   duty_c;
    logic [SW-1:0]   stuck_step_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CW'(CNT_MAX)) ? v : v + CW'(1);
    endfunction

    // Edge strobes from the synchronized waveform
    assign rise_c = wave_s & ~wave_d;
    assign fall_c = ~wave_s & wave_d;

    // Period and duty derived from the counters at the closing rise
    assign period_c     = PW'(high_cnt) + PW'(low_cnt);
    assign period_ok_c  = (period_c >= PW'(P_MIN)) && (period_c <= PW'(P_MAX));
    assign duty_c       = (high_cnt > CW'(STEP_MAX)) ? SW'(STEP_MAX) : high_cnt[SW-1:0];
    assign idle_hit_c   = (idle_cnt >= CW'(PERIOD));
    assign stuck_step_c = wave_s ? SW'(STEP_MAX) : SW'(0);

    // Input synchronizer and edge-detect delay
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q1 <= 1'b0;
            wave_s  <= 1'b0;
            wave_d  <= 1'b0;
        end else begin
            sync_q1 <= wave_i;
            wave_s  <= sync_q1;
            wave_d  <= wave_s;
        end
    end

    // State, measurement counters and the pending-report stage
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            high_cnt   <= '0;
            low_cnt    <= '0;
            idle_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_err   <= 1'b0;
            pend_step  <= '0;
        end else begin
            state      <= state_nx;
            high_cnt   <= high_nx;
            low_cnt    <= low_nx;
            idle_cnt   <= (rise_c || fall_c) ? CW'(0) : sat_inc(idle_cnt);
            pend_valid <= pend_valid_nx;
            pend_err   <= pend_err_nx;
            pend_step  <= pend_step_nx;
        end
    end

    // Next-state logic; a rise always wins over a timeout in the same cycle
    always_comb begin
        state_nx      = state;
        high_nx       = high_cnt;
        low_nx        = low_cnt;
        pend_valid_nx = 1'b0;
        pend_err_nx   = 1'b0;
        pend_step_nx  = pend_step;
        case (state)
            IDLE: begin
                if (rise_c) begin
                    state_nx = HIGH;
                    high_nx  = CW'(1);
                    low_nx   = '0;
                end else if (idle_hit_c) begin
                    state_nx      = STUCK;
                    pend_valid_nx = 1'b1;
                    pend_step_nx  = stuck_step_c;
                end
            end
            HIGH: begin
                if (fall_c) begin
                    state_nx = LOW;
                    low_nx   = CW'(1);
                end else if (idle_hit_c) begin
                    state_nx      = STUCK;
                    pend_valid_nx = 1'b1;
                    pend_step_nx  = stuck_step_c;
                end else begin
                    high_nx = sat_inc(high_cnt);
                end
            end
            LOW: begin
                if (rise_c) begin
                    state_nx = HIGH;
                    high_nx  = CW'(1);
                    low_nx   = '0;
                    if (period_ok_c) begin
                        pend_valid_nx = 1'b1;
                        pend_step_nx  = duty_c;
                    end else begin
                        pend_err_nx = 1'b1;
                    end
                end else if (idle_hit_c) begin
                    state_nx      = STUCK;
                    pend_valid_nx = 1'b1;
                    pend_step_nx  = stuck_step_c;
                end else begin
                    low_nx = sat_inc(low_cnt);
                end
            end
            STUCK: begin
                // A rise starts a fresh measurement; the partial period is not evaluated
                if (rise_c) begin
                    state_nx = HIGH;
                    high_nx  = CW'(1);
                    low_nx   = '0;
                end else if (fall_c) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs; step_o only moves together with valid_o
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            step_o       <= '0;
            valid_o      <= 1'b0;
            period_err_o <= 1'b0;
            locked_o     <= 1'b0;
        end else begin
            valid_o      <= pend_valid;
            period_err_o <= pend_err;
            if (pend_valid) begin
                step_o   <= pend_step;
                locked_o <= 1'b1;
            end else if (pend_err) begin
                locked_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed, table-driven checks of pwm_capture with default parameters.
module tb_pwm_capture;

    logic       CLK;
    logic       RST_N;
    logic       wave_i;
    logic [7:0] step_o;
    logic       valid_o;
    logic       period_err_o;
    logic       locked_o;

    pwm_capture dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .wave_i       (wave_i),
        .step_o       (step_o),
        .valid_o      (valid_o),
        .period_err_o (period_err_o),
        .locked_o     (locked_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fails = 0;

    // Free-running monitor: strobe counts and invariant violations
    int         n_valid  = 0;
    int         n_err    = 0;
    int         mon_errs = 0;
    logic [7:0] prev_step = 8'h00;
    logic       prev_rst_ok = 1'b0;

    always @(negedge CLK) begin
        if (valid_o === 1'b1) n_valid = n_valid + 1;
        if (period_err_o === 1'b1) n_err = n_err + 1;
        if (valid_o === 1'b1 && period_err_o === 1'b1) begin
            mon_errs = mon_errs + 1;
            $display("FAIL strobe_excl: valid_o and period_err_o both 1 at %0t", $time);
        end
        if (prev_rst_ok && valid_o !== 1'b1 && step_o !== prev_step) begin
            mon_errs = mon_errs + 1;
            $display("FAIL step_hold: step_o moved %02h -> %02h without valid_o at %0t",
                     prev_step, step_o, $time);
        end
        prev_step   = step_o;
        prev_rst_ok = (RST_N === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_phase(input logic lvl, input int n);
        wave_i = lvl;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        wave_i = 1'b0;
        RST_N  = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // k full periods, then a closing rise held long enough for the report to emerge
    task automatic run_pwm(input int hi, input int lo, input int k);
        for (int i = 0; i < k; i++) begin
            run_phase(1'b1, hi);
            run_phase(1'b0, lo);
        end
        run_phase(1'b1, 8);
    endtask

    typedef struct {
        int         hi;
        int         lo;
        int         k;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_step;
        logic       exp_lock;
    } vec_t;

    vec_t vecs[8];
    int   bv, be;

    initial begin
        vecs[0] = '{hi: 64,  lo: 192, k: 3, exp_valid: 3, exp_err: 0, exp_step: 8'h40, exp_lock: 1'b1};
        vecs[1] = '{hi: 50,  lo: 150, k: 3, exp_valid: 0, exp_err: 3, exp_step: 8'h00, exp_lock: 1'b0};
        vecs[2] = '{hi: 192, lo: 64,  k: 2, exp_valid: 2, exp_err: 0, exp_step: 8'hC0, exp_lock: 1'b1};
        vecs[3] = '{hi: 255, lo: 1,   k: 2, exp_valid: 2, exp_err: 0, exp_step: 8'hFF, exp_lock: 1'b1};
        vecs[4] = '{hi: 1,   lo: 255, k: 2, exp_valid: 2, exp_err: 0, exp_step: 8'h01, exp_lock: 1'b1};
        vecs[5] = '{hi: 128, lo: 128, k: 2, exp_valid: 2, exp_err: 0, exp_step: 8'h80, exp_lock: 1'b1};
        vecs[6] = '{hi: 100, lo: 100, k: 2, exp_valid: 0, exp_err: 2, exp_step: 8'h00, exp_lock: 1'b0};
        vecs[7] = '{hi: 128, lo: 129, k: 2, exp_valid: 0, exp_err: 2, exp_step: 8'h00, exp_lock: 1'b0};

        // Reset state
        wave_i = 1'b0;
        RST_N  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_step",   32'(step_o), 32'h00);
        check("rst_valid",  32'(valid_o), 32'h0);
        check("rst_err",    32'(period_err_o), 32'h0);
        check("rst_locked", 32'(locked_o), 32'h0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Table of steady patterns
        for (int i = 0; i < 8; i++) begin
            do_reset();
            bv = n_valid;
            be = n_err;
            run_pwm(vecs[i].hi, vecs[i].lo, vecs[i].k);
            check($sformatf("vec%0d_valid_cnt", i), 32'(n_valid - bv), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err_cnt", i),   32'(n_err - be),   32'(vecs[i].exp_err));
            check($sformatf("vec%0d_step", i),      32'(step_o),       32'(vecs[i].exp_step));
            check($sformatf("vec%0d_locked", i),    32'(locked_o),     32'(vecs[i].exp_lock));
        end

        // Report latency: valid_o three edges after the rise is first sampled
        do_reset();
        run_phase(1'b1, 64);
        run_phase(1'b0, 192);
        wave_i = 1'b1;
        repeat (4) @(negedge CLK);
        check("lat_early_valid", 32'(valid_o), 32'h0);
        @(negedge CLK);
        check("lat_valid", 32'(valid_o), 32'h1);
        check("lat_step",  32'(step_o),  32'h40);
        @(negedge CLK);
        check("lat_strobe_width", 32'(valid_o), 32'h0);

        // Input held low: one timeout report of 0x00
        do_reset();
        bv = n_valid;
        be = n_err;
        run_phase(1'b0, 400);
        check("low_valid_cnt", 32'(n_valid - bv), 32'd1);
        check("low_err_cnt",   32'(n_err - be),   32'd0);
        check("low_step",      32'(step_o),       32'h00);
        check("low_locked",    32'(locked_o),     32'h1);

        // Duty switched at a period boundary
        do_reset();
        bv = n_valid;
        run_phase(1'b1, 64);  run_phase(1'b0, 192);
        run_phase(1'b1, 64);  run_phase(1'b0, 192);
        run_phase(1'b1, 192); run_phase(1'b0, 64);
        run_phase(1'b1, 8);
        check("switch_valid_cnt", 32'(n_valid - bv), 32'd3);
        check("switch_step",      32'(step_o),       32'hC0);

        // Reset during the high phase of a 0x80 stream
        do_reset();
        run_pwm(128, 128, 2);
        run_phase(1'b1, 32);
        RST_N = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("midrst_step",   32'(step_o),       32'h00);
        check("midrst_valid",  32'(valid_o),      32'h0);
        check("midrst_err",    32'(period_err_o), 32'h0);
        check("midrst_locked", 32'(locked_o),     32'h0);
        bv = n_valid;
        @(posedge CLK);
        #1;
        run_phase(1'b1, 88);
        run_phase(1'b0, 128);
        run_phase(1'b1, 128);
        check("midrst_first_rise_valid", 32'(n_valid - bv), 32'd0);
        run_phase(1'b0, 128);
        run_phase(1'b1, 8);
        check("midrst_second_rise_valid", 32'(n_valid - bv), 32'd1);
        check("midrst_second_rise_step",  32'(step_o),       32'h80);

        // Stuck high, then 0x20 PWM
        do_reset();
        bv = n_valid;
        be = n_err;
        run_phase(1'b1, 300);
        check("stuckhi_valid_cnt", 32'(n_valid - bv), 32'd1);
        check("stuckhi_step",      32'(step_o),       32'hFF);
        check("stuckhi_locked",    32'(locked_o),     32'h1);
        run_phase(1'b0, 224);
        run_phase(1'b1, 32);
        check("stuckhi_rise1_noreport", 32'(n_valid - bv), 32'd1);
        run_phase(1'b0, 224);
        run_phase(1'b1, 8);
        check("stuckhi_rise2_valid_cnt", 32'(n_valid - bv), 32'd2);
        check("stuckhi_rise2_step",      32'(step_o),       32'h20);
        check("stuckhi_err_cnt",         32'(n_err - be),   32'd0);

        check("monitor_invariants", 32'(mon_errs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter PERIOD, default 256: nominal PWM period in CLK cycles, matching the 8-bit free-running PWM counter.
REQ-002 Parameter TOL, default 0: accepted period deviation in cycles; the legal period is PERIOD-TOL..PERIOD+TOL inclusive.
REQ-003 CLK  input  1  sole clock; all logic on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 wave_i  input  1  asynchronous PWM waveform; high = on.
REQ-006 step_o  output  8  last measured duty (high cycles per period).
REQ-007 valid_o  output  1  one-cycle strobe; step_o updated this cycle.
REQ-008 period_err_o  output  1  one-cycle strobe; measured period outside the legal range.
REQ-009 locked_o  output  1  level; a good measurement has been taken since the last error or reset.

Function
REQ-010 wave_i SHALL pass a 2-flop synchronizer to give wave_s; wave_d SHALL be wave_s delayed by one cycle.
REQ-011 rise = wave_s & ~wave_d; fall = ~wave_s & wave_d; both SHALL be single-cycle internal strobes.
REQ-012 FSM states: IDLE, HIGH, LOW, STUCK; the reset state SHALL be IDLE.
REQ-013 IDLE: rise -> HIGH with high_cnt=1, low_cnt=0; no measurement is reported.
REQ-014 HIGH: high_cnt +1 per cycle; fall -> LOW with low_cnt=1.
REQ-015 LOW: low_cnt +1 per cycle; rise -> HIGH, evaluate the period, then restart with high_cnt=1 and low_cnt=0.
REQ-016 Period evaluation: p = high_cnt + low_cnt; counters are 10-bit and saturate at 1023.
REQ-017 If p is legal, the next cycle SHALL have step_o = min(high_cnt,255), valid_o=1, and locked_o set.
REQ-018 If p is illegal, the next cycle SHALL have period_err_o=1 and locked_o cleared; step_o is held.
REQ-019 idle_cnt SHALL clear on rise or fall and otherwise increment, saturating.
REQ-020 In IDLE/HIGH/LOW, idle_cnt reaching PERIOD SHALL enter STUCK. The next cycle SHALL have valid_o=1, locked_o=1, and step_o=0xFF if wave_s=1 or 0x00 if wave_s=0.
REQ-021 STUCK: exactly one valid_o pulse per episode; rise -> HIGH (high_cnt=1), starting a fresh measurement with no evaluation; fall -> IDLE.
REQ-022 Latency: a wave_i rise first sampled at edge N SHALL produce rise at edge N+2 and valid_o/period_err_o at edge N+3.
REQ-023 valid_o and period_err_o SHALL never assert in the same cycle.
REQ-024 A rise arriving in the same cycle as idle_cnt reaching PERIOD SHALL take priority; no STUCK entry occurs.
REQ-025 step_o SHALL change only in a cycle with valid_o=1.

Reset
REQ-026 With RST_N low at a CLK edge, the block SHALL go to: state IDLE; all counters 0; synchronizer flops 0; step_o=0x00; valid_o=0; period_err_o=0; locked_o=0.
REQ-027 Reset mid-measurement SHALL discard partial counts; the first report after reset requires two rises, or a timeout.

Verification
REQ-028 PWM 64 high / 192 low, repeated -> valid_o 3 cycles after each 2nd-and-later rise, step_o=0x40, locked_o=1, period_err_o never asserts.
REQ-029 wave_i held low for 400 cycles after reset -> exactly one valid_o, step_o=0x00, locked_o=1; no further strobes.
REQ-030 Pattern 50 high / 150 low (period 200), TOL=0 -> period_err_o each period, valid_o never asserts, locked_o=0.
REQ-031 Duty switched from 0x40 to 0xC0 at a period boundary -> next report step_o=0xC0; 255 high / 1 low -> step_o=0xFF.
REQ-032 RST_N low for 1 cycle during HIGH of a steady 0x80 stream -> outputs zero. The next valid_o follows the 2nd post-reset rise, with step_o=0x80.
REQ-033 Constant high for 300 cycles, then 0x20 PWM -> one valid_o with step_o=0xFF. The first rise after that gives no report; the following rise reports step_o=0x20.
